dsp_post_adder_stage: RTL and testbench

//  Post-adder/accumulator stage of the DSP48A1 slice: consumes the multiplier product M and
//  the concatenated D:A:B bus, selects X/Z operands per OPMODE, adds or subtracts with carry-in,
//  and registers the 48-bit result P, CARRYOUT and an output-valid flag. Sits directly

---
 rtl/dsp_post_adder_stage_pkg.sv | 46 ++++
 rtl/dsp_post_adder_stage_if.sv | 32 +++
 rtl/dsp_post_adder_stage_pipe_reg.sv | 33 +++
 rtl/dsp_post_adder_stage.sv | 119 +++++++++++
 tb/tb_dsp_post_adder_stage.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_post_adder_stage_pkg.sv
// Shared definitions for the DSP48A1 post-adder stage: operand widths,
// OPMODE field positions, X/Z mux codes and the post-adder arithmetic.
package dsp48a1_pkg;

   localparam int M_W = 36;   // multiplier product width
   localparam int P_W = 48;   // post-adder / P width

   // OPMODE bit positions
   localparam int X_LSB   = 0;
   localparam int Z_LSB   = 2;
   localparam int CIN_BIT = 5;
   localparam int SUB_BIT = 7;

   // X mux codes (OPMODE[1:0])
   localparam logic [1:0] X_ZERO = 2'd0;
   localparam logic [1:0] X_M    = 2'd1;
   localparam logic [1:0] X_P    = 2'd2;
   localparam logic [1:0] X_DAB  = 2'd3;

   // Z mux codes (OPMODE[3:2])
   localparam logic [1:0] Z_ZERO = 2'd0;
   localparam logic [1:0] Z_PCIN = 2'd1;
   localparam logic [1:0] Z_P    = 2'd2;
   localparam logic [1:0] Z_C    = 2'd3;

   // 49-bit post-adder result: carry/borrow bit above the 48-bit P value.
   typedef struct packed {
      logic           carry;
      logic [P_W-1:0] p;
   } post_sum_t;

   // Z + X + CIN, or Z - (X + CIN); operands are unsigned and widened by one bit
   // so bit 48 is the carry-out (add) or the borrow indication (subtract).
   function automatic post_sum_t post_add(input logic [P_W-1:0] z,
                                          input logic [P_W-1:0] x,
                                          input logic           cin,
                                          input logic           sub);
      logic [P_W:0] cin_w;
      logic [P_W:0] r;
      cin_w = {{P_W{1'b0}}, cin};
      if (sub) r = {1'b0, z} - ({1'b0, x} + cin_w);
      else     r = {1'b0, z} + {1'b0, x} + cin_w;
      return post_sum_t'(r);
   endfunction

endpackage

// File: rtl/dsp_post_adder_stage_if.sv
// Operand, control and result bundle between the multiplier stage (master)
// and the post-adder stage (slave).
interface dsp_post_adder_stage_if;
   import dsp48a1_pkg::*;

   logic [M_W-1:0] M;
   logic [P_W-1:0] DAB;
   logic [P_W-1:0] C;
   logic [P_W-1:0] PCIN;
   logic [7:0]     OPMODE;
   logic           CARRYIN;
   logic           CECARRYIN;
   logic           CEP;
   logic           in_valid;

   logic [P_W-1:0] P;
   logic [P_W-1:0] PCOUT;
   logic           CARRYOUT;
   logic           CARRYOUTF;
   logic           out_valid;

   modport master (
      output M, DAB, C, PCIN, OPMODE, CARRYIN, CECARRYIN, CEP, in_valid,
      input  P, PCOUT, CARRYOUT, CARRYOUTF, out_valid
   );

   modport slave (
      input  M, DAB, C, PCIN, OPMODE, CARRYIN, CECARRYIN, CEP, in_valid,
      output P, PCOUT, CARRYOUT, CARRYOUTF, out_valid
   );

endinterface

// File: rtl/dsp_post_adder_stage_pipe_reg.sv
// Enable-gated pipeline register with asynchronous active-low clear.
// REG_EN=0 turns it into a wire so the same instance covers both options.
module dsp_pipe_reg #(
   parameter int N      = 1,
   parameter int REG_EN = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] q_o
);

   generate
      if (REG_EN != 0) begin : g_reg
         logic [N-1:0] data_q;

         // Load on enabled edges, hold otherwise, clear on reset.
         always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (!rst_n)    data_q <= '0;
            else if (en_i) data_q <= d_i;
         end

         assign q_o = data_q;
      end else begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst_n, en_i};
         assign q_o = d_i;
      end
   endgenerate

endmodule

// File: rtl/dsp_post_adder_stage.sv
// DSP48A1 post-adder/accumulator: selects X/Z operands from OPMODE, adds or
// subtracts with carry-in and registers P, CARRYOUT and the output-valid flag.
module dsp_post_adder_stage
   import dsp48a1_pkg::*;
#(
   parameter int    PREG        = 1,
   parameter int    CARRYINREG  = 1,
   parameter int    CARRYOUTREG = 1,
   parameter string CARRYINSEL  = "OPMODE5"
) (
   input logic                   clk,
   input logic                   rst_n,
   dsp_post_adder_stage_if.slave pa_if
);

   logic           cin_d;
   logic           cin_q;
   logic [P_W-1:0] p_q;
   logic [P_W-1:0] p_fb;
   logic [P_W-1:0] x_mux;
   logic [P_W-1:0] z_mux;
   post_sum_t      sum_d;
   logic           carry_q;
   logic           valid_q;

   // Only some OPMODE bits / carry sources are used by any one configuration.
   logic unused_sel;
   assign unused_sel = ^{pa_if.OPMODE[6:4], pa_if.CARRYIN};

   // Carry-in source chosen at elaboration.
   generate
      if (CARRYINSEL == "OPMODE5") begin : g_cin_opmode
         assign cin_d = pa_if.OPMODE[CIN_BIT];
      end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
         assign cin_d = pa_if.CARRYIN;
      end else begin : g_cin_bad
         $error("dsp_post_adder_stage: CARRYINSEL must be \"OPMODE5\" or \"CARRYIN\"");
         assign cin_d = 1'b0;
      end
   endgenerate

   // Carry-in register lines the carry up with the upstream M register.
   dsp_pipe_reg #(.N(1), .REG_EN(CARRYINREG)) u_cin_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (pa_if.CECARRYIN),
      .d_i   (cin_d),
      .q_o   (cin_q)
   );

   // Without a P register there is nothing legal to feed back; tie it off so
   // the netlist never contains a structural loop.
   assign p_fb = (PREG != 0) ? p_q : '0;

   // X/Z operand selection from OPMODE.
   always_comb begin
      // NOTE: defaults first so no path through the case infers a latch.
      x_mux = '0;
      z_mux = '0;
      case (pa_if.OPMODE[X_LSB +: 2])
         X_M:     x_mux = {{(P_W-M_W){1'b0}}, pa_if.M};
         X_P:     x_mux = p_fb;
         X_DAB:   x_mux = pa_if.DAB;
         default: x_mux = '0;
      endcase
      case (pa_if.OPMODE[Z_LSB +: 2])
         Z_PCIN:  z_mux = pa_if.PCIN;
         Z_P:     z_mux = p_fb;
         Z_C:     z_mux = pa_if.C;
         default: z_mux = '0;
      endcase
   end

   assign sum_d = post_add(z_mux, x_mux, cin_q, pa_if.OPMODE[SUB_BIT]);

   // Result, carry-out and valid share the CEP enable and reset.
   dsp_pipe_reg #(.N(P_W), .REG_EN(PREG)) u_p_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (pa_if.CEP),
      .d_i   (sum_d.p),
      .q_o   (p_q)
   );

   dsp_pipe_reg #(.N(1), .REG_EN(CARRYOUTREG)) u_carry_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (pa_if.CEP),
      .d_i   (sum_d.carry),
      .q_o   (carry_q)
   );

   dsp_pipe_reg #(.N(1), .REG_EN(PREG)) u_valid_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (pa_if.CEP),
      .d_i   (pa_if.in_valid),
      .q_o   (valid_q)
   );

   assign pa_if.P         = p_q;
   assign pa_if.PCOUT     = p_q;
   assign pa_if.CARRYOUT  = carry_q;
   assign pa_if.CARRYOUTF = carry_q;
   assign pa_if.out_valid = valid_q;

   generate
      if (PREG == 0) begin : g_comb_p_check
         // Selecting P with no P register would close a combinational loop.
         always_comb begin
            if (rst_n) begin
               assert (pa_if.OPMODE[X_LSB +: 2] != X_P && pa_if.OPMODE[Z_LSB +: 2] != Z_P)
                  else $error("dsp_post_adder_stage: OPMODE selects P while PREG=0");
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_dsp_post_adder_stage.sv
// Bench for dsp_post_adder_stage: two instances (carry-in from OPMODE[5] and
// from the CARRYIN port) share one stimulus stream; a reference model pushes
// expected results into a queue and a monitor compares on every enabled edge.
module tb_dsp_post_adder_stage;
   import dsp48a1_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   dsp_post_adder_stage_if bus0 ();
   dsp_post_adder_stage_if bus1 ();

   dsp_post_adder_stage dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .pa_if (bus0)
   );

   dsp_post_adder_stage #(.CARRYINSEL("CARRYIN")) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .pa_if (bus1)
   );

   typedef struct {
      bit          v;
      logic [47:0] p0;
      bit          c0;
      logic [47:0] p1;
      bit          c1;
   } exp_t;

   exp_t exp_q[$];
   exp_t held;
   bit   have_held = 1'b0;

   int total = 0;
   int bad   = 0;

   // Reference state: P and the carry value each instance will use next.
   logic [47:0] mp0   = '0;
   logic [47:0] mp1   = '0;
   bit          mcin0 = 1'b0;
   bit          mcin1 = 1'b0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Plain 64-bit arithmetic of the post-adder rules; low 49 bits are {CARRYOUT,P}.
   function automatic logic [48:0] ref_sum(input logic [7:0] op, input logic [35:0] m,
                                           input logic [47:0] dab, input logic [47:0] c,
                                           input logic [47:0] pcin, input logic [47:0] p,
                                           input bit cin);
      logic [63:0] xv;
      logic [63:0] zv;
      logic [63:0] r;
      case (op[1:0])
         2'd0:    xv = 64'd0;
         2'd1:    xv = 64'(m);
         2'd2:    xv = 64'(p);
         default: xv = 64'(dab);
      endcase
      case (op[3:2])
         2'd0:    zv = 64'd0;
         2'd1:    zv = 64'(pcin);
         2'd2:    zv = 64'(p);
         default: zv = 64'(c);
      endcase
      if (op[7]) r = zv - xv - 64'(cin);
      else       r = zv + xv + 64'(cin);
      return r[48:0];
   endfunction

   // Drive one cycle on both buses, predict the post-edge state, advance one clock.
   task automatic step(input logic [7:0] op, input logic [35:0] m, input logic [47:0] dab,
                       input logic [47:0] c, input logic [47:0] pcin, input bit cy,
                       input bit ce_cy, input bit cep, input bit vld);
      exp_t        e;
      logic [48:0] s0;
      logic [48:0] s1;
      bus0.OPMODE = op;  bus0.M = m;  bus0.DAB = dab;  bus0.C = c;  bus0.PCIN = pcin;
      bus0.CARRYIN = cy; bus0.CECARRYIN = ce_cy; bus0.CEP = cep; bus0.in_valid = vld;
      bus1.OPMODE = op;  bus1.M = m;  bus1.DAB = dab;  bus1.C = c;  bus1.PCIN = pcin;
      bus1.CARRYIN = cy; bus1.CECARRYIN = ce_cy; bus1.CEP = cep; bus1.in_valid = vld;
      s0 = ref_sum(op, m, dab, c, pcin, mp0, mcin0);
      s1 = ref_sum(op, m, dab, c, pcin, mp1, mcin1);
      if (cep) begin
         e.v  = vld;
         e.p0 = s0[47:0];
         e.c0 = s0[48];
         e.p1 = s1[47:0];
         e.c1 = s1[48];
         exp_q.push_back(e);
         mp0 = s0[47:0];
         mp1 = s1[47:0];
      end
      if (ce_cy) begin
         mcin0 = op[5];
         mcin1 = cy;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic compare_all(input exp_t e, input string tag);
      check({tag, " out_valid0"}, 48'(bus0.out_valid), 48'(e.v));
      check({tag, " P0"},         bus0.P,               e.p0);
      check({tag, " PCOUT0"},     bus0.PCOUT,           e.p0);
      check({tag, " CARRYOUT0"},  48'(bus0.CARRYOUT),   48'(e.c0));
      check({tag, " CARRYOUTF0"}, 48'(bus0.CARRYOUTF),  48'(e.c0));
      check({tag, " out_valid1"}, 48'(bus1.out_valid), 48'(e.v));
      check({tag, " P1"},         bus1.P,               e.p1);
      check({tag, " PCOUT1"},     bus1.PCOUT,           e.p1);
      check({tag, " CARRYOUT1"},  48'(bus1.CARRYOUT),   48'(e.c1));
      check({tag, " CARRYOUTF1"}, 48'(bus1.CARRYOUTF),  48'(e.c1));
   endtask

   // Monitor: pop on every enabled edge; with CEP low the outputs must stay frozen.
   initial begin
      bit cap;
      forever begin
         @(posedge clk);
         cap = bus0.CEP && rst_n;
         @(negedge clk);
         if (cap) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard_empty: got output with no expectation at %0t", $time);
            end else begin
               held      = exp_q.pop_front();
               have_held = 1'b1;
               compare_all(held, "pop");
            end
         end else if (rst_n && have_held) begin
            compare_all(held, "frozen");
         end
      end
   end

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic reset_mid_cycle();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst P0",         bus0.P,                  48'h0);
      check("rst CARRYOUT0",  48'(bus0.CARRYOUT),      48'h0);
      check("rst out_valid0", 48'(bus0.out_valid),     48'h0);
      check("rst P1",         bus1.P,                  48'h0);
      check("rst out_valid1", 48'(bus1.out_valid),     48'h0);
      exp_q.delete();
      have_held = 1'b0;
      mp0 = '0;  mp1 = '0;  mcin0 = 1'b0;  mcin1 = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

   initial begin
      logic [7:0]  op;
      logic [35:0] m;
      logic [47:0] dab;
      logic [47:0] c;
      logic [47:0] pcin;

      bus0.OPMODE = '0; bus0.M = '0; bus0.DAB = '0; bus0.C = '0; bus0.PCIN = '0;
      bus0.CARRYIN = 1'b0; bus0.CECARRYIN = 1'b0; bus0.CEP = 1'b0; bus0.in_valid = 1'b0;
      bus1.OPMODE = '0; bus1.M = '0; bus1.DAB = '0; bus1.C = '0; bus1.PCIN = '0;
      bus1.CARRYIN = 1'b0; bus1.CECARRYIN = 1'b0; bus1.CEP = 1'b0; bus1.in_valid = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("por P0",         bus0.P,              48'h0);
      check("por out_valid0", 48'(bus0.out_valid), 48'h0);
      rst_n = 1'b1;

      // Multiply-add: X=M, Z=C -> 6 + 10
      step(8'h0D, 36'd6, 48'd0, 48'd10, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      // Load P=0x123 via X=DAB, then reset between edges
      step(8'h03, 36'd0, 48'h123, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      reset_mid_cycle();

      // Accumulate from the fresh post-reset P=0: X=M, Z=P
      repeat (4) step(8'h09, 36'd5, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1);

      // Overflow with CIN=1; issued twice so the registered carry is 1 on the second
      repeat (2) step(8'h2F, 36'd0, 48'd0, ONES, 48'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      // Subtract to borrow: Z=C=0, X=0
      step(8'h8C, 36'd0, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      // Subtract with carry: 100 - (9 + CIN)
      repeat (2) step(8'hAF, 36'd0, 48'd9, 48'd100, 48'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      // Cascade input and doubling accumulate (X=P, Z=P)
      step(8'h07, 36'd0, 48'd3, 48'd0, 48'h8000_0000_0001, 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (2) step(8'h0A, 36'd0, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b1);

      // CEP low for three cycles while inputs change: outputs frozen
      for (int i = 0; i < 3; i++)
         step(8'($urandom), 36'($urandom), 48'($urandom), 48'($urandom), 48'($urandom),
              1'($urandom), 1'b1, 1'b0, 1'($urandom));

      // Held carry: capture CARRYIN=1, then toggle it with CECARRYIN low
      step(8'h0D, 36'd1, 48'd0, 48'd1, 48'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++)
         step(8'h0D, 36'd1, 48'd0, 48'd1, 48'd0, 1'(i % 2), 1'b0, 1'b1, 1'b1);

      // Randomised traffic including all-ones corners
      for (int i = 0; i < 300; i++) begin
         op   = 8'($urandom);
         m    = 36'({$urandom(), $urandom()});
         dab  = ($urandom_range(0, 7) == 0) ? ONES : 48'({$urandom(), $urandom()});
         c    = ($urandom_range(0, 7) == 0) ? ONES : 48'({$urandom(), $urandom()});
         pcin = 48'({$urandom(), $urandom()});
         step(op, m, dab, c, pcin, 1'($urandom), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 4) != 0), 1'($urandom));
      end

      step(8'h00, 36'd0, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
